// File: rtl/k2_uart_pkg.sv
// Shared types and helpers for the K2 output-register UART transmitter.
// The optional parity state is only reachable when K2_UART_PARITY_EN is defined.
package k2_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // '0'-'9' then 'A'-'F'
  function automatic logic [7:0] hex2ascii(input logic [3:0] v);
    logic [7:0] r;
    if (v < 4'd10) r = 8'h30 + {4'h0, v};
    else           r = 8'h41 + ({4'h0, v} - 8'd10);
    return r;
  endfunction

endpackage

// File: rtl/k2_sync_fifo.sv
// Small synchronous FIFO with count-based full/empty and a drop indicator.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module k2_sync_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];

  // When full, the slot being written is the one being read out this edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/k2_out_uart_tx.sv
// Captures K2 RO writes into a FIFO and sends each as an ASCII hex char on a UART line.
// Define K2_UART_PARITY_EN for 8E1 frames (extra even-parity bit); default is 8N1.
module k2_out_uart_tx
  import k2_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              out_wen,
  input  logic [DATA_W-1:0] out_data,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow,
  output uart_state_e       dbg_state_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q;
  logic              baud_end;
  logic              fifo_pop, fifo_empty, fifo_drop;
  logic [DATA_W-1:0] fifo_head;
`ifdef K2_UART_PARITY_EN
  logic              par_q, par_d;
`endif

  // Handshake: the core's out_wen is a one-cycle valid with no ready; the
  // FIFO accepts it unless full-without-pop, in which case it is dropped and
  // flagged. The FSM is the FIFO consumer: fifo_pop is only raised while the
  // FIFO is non-empty, and the head is consumed on that same edge.
  k2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (out_wen),
    .pop_i   (fifo_pop),
    .din_i   (out_data),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = IDLE_LEVEL;
    fifo_pop = 1'b0;
`ifdef K2_UART_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = hex2ascii(fifo_head[3:0]);
`ifdef K2_UART_PARITY_EN
          par_d    = ^hex2ascii(fifo_head[3:0]);
`endif
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = START_LEVEL;
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef K2_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef K2_UART_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q;
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_d = IDLE_LEVEL;
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // tx is registered, so the line trails the state register by one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_q | fifo_drop;
    end
  end

`ifdef K2_UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (!resetn) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`endif

  assign tx          = tx_q;
  assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_k2_out_uart_tx.sv
// Directed bench for k2_out_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frame checks follow K2_UART_PARITY_EN when it is defined for the build.
module tb_k2_out_uart_tx;
  import k2_uart_pkg::*;

  localparam int C = 4;
`ifdef K2_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        resetn;
  logic        out_wen;
  logic [3:0]  out_data;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  uart_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  logic idle_ok;

  k2_out_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (4),
    .DATA_W       (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .out_wen     (out_wen),
    .out_data    (out_data),
    .tx          (tx),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_one(input logic [3:0] v);
    out_data = v;
    out_wen  = 1'b1;
    tick();
    out_wen  = 1'b0;
  endtask

  // Samples the line once per cycle from frame sample 'skip' onward.
  task automatic check_frame(input logic [7:0] ch, input int skip, input bit last,
                             input string tag);
    logic [10:0] fr;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = ch;
`ifdef K2_UART_PARITY_EN
    fr[9]   = ^ch;
`endif
    for (int s = skip; s < NB*C; s++) begin
      tick();
      chk($sformatf("%s_bit%0d_s%0d", tag, s/C, s%C), 32'(tx), 32'(fr[s/C]));
      if (last && s == NB*C-2) chk({tag, "_busy_stop"}, 32'(busy), 32'd1);
      if (last && s == NB*C-1) chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic gap(input string tag);
    tick();
    chk({tag, "_gap"}, 32'(tx), 32'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    out_wen  = 1'b0;
    out_data = 4'h0;

    // Reset state
    tick();
    tick();
    chk("rst_tx",       32'(tx),        32'd1);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_full",     32'(fifo_full), 32'd0);
    chk("rst_state",    32'(dbg_state), 32'(ST_IDLE));
    resetn  = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle50", 32'(idle_ok), 32'd1);

    // Single write of 'A' -> 0x41
    write_one(4'hA);
    chk("a_busy_queued", 32'(busy), 32'd1);
    tick();
    chk("a_lat_n1_tx",    32'(tx),        32'd1);
    chk("a_lat_n1_state", 32'(dbg_state), 32'(ST_START));
    check_frame(8'h41, 0, 1'b1, "a");

    // Burst of five: '1' popped at once, 2..5 fill the FIFO
    for (int i = 1; i <= 5; i++) begin
      out_data = 4'(i);
      out_wen  = 1'b1;
      tick();
      chk($sformatf("burst_w%0d_tx", i), 32'(tx), (i >= 3) ? 32'd0 : 32'd1);
    end
    out_wen = 1'b0;
    chk("burst_full",     32'(fifo_full), 32'd1);
    chk("burst_overflow", 32'(overflow),  32'd0);
    check_frame(8'h31, 3, 1'b0, "b1");

    // Write on the IDLE pop edge while full: accepted
    out_data = 4'hC;
    out_wen  = 1'b1;
    tick();
    out_wen  = 1'b0;
    chk("pop_push_tx",       32'(tx),        32'd1);
    chk("pop_push_full",     32'(fifo_full), 32'd1);
    chk("pop_push_overflow", 32'(overflow),  32'd0);
    chk("pop_push_state",    32'(dbg_state), 32'(ST_START));
    check_frame(8'h32, 0, 1'b0, "b2");
    gap("b2");
    check_frame(8'h33, 0, 1'b0, "b3");
    gap("b3");
    check_frame(8'h34, 0, 1'b0, "b4");
    gap("b4");
    check_frame(8'h35, 0, 1'b0, "b5");
    gap("b5");
    check_frame(8'h43, 0, 1'b1, "bC");
    chk("burst_end_overflow", 32'(overflow), 32'd0);

    // Six writes 6..B: B is dropped, overflow sticks
    for (int i = 0; i < 6; i++) begin
      out_data = 4'(6 + i);
      out_wen  = 1'b1;
      tick();
      chk($sformatf("ovf_w%0d_tx", i), 32'(tx), (i >= 2) ? 32'd0 : 32'd1);
      if (i == 4) begin
        chk("ovf_w4_full",     32'(fifo_full), 32'd1);
        chk("ovf_w4_overflow", 32'(overflow),  32'd0);
      end
      if (i == 5) chk("ovf_w5_overflow", 32'(overflow), 32'd1);
    end
    out_wen = 1'b0;
    check_frame(8'h36, 4, 1'b0, "o6");
    gap("o6");
    check_frame(8'h37, 0, 1'b0, "o7");
    gap("o7");
    check_frame(8'h38, 0, 1'b0, "o8");
    gap("o8");
    check_frame(8'h39, 0, 1'b0, "o9");
    gap("o9");
    check_frame(8'h41, 0, 1'b1, "oA");
    chk("ovf_sticky", 32'(overflow),  32'd1);
    chk("ovf_drained", 32'(fifo_full), 32'd0);

    // Mid-frame reset during DATA bit 3, with 'B' still queued
    write_one(4'hA);
    write_one(4'hB);
    for (int i = 0; i < 16; i++) tick();
    chk("mid_state_data", 32'(dbg_state), 32'(ST_DATA));
    chk("mid_tx_bit2",    32'(tx),        32'd0);
    resetn = 1'b0;
    tick();
    chk("mid_rst_tx",       32'(tx),        32'd1);
    chk("mid_rst_busy",     32'(busy),      32'd0);
    chk("mid_rst_full",     32'(fifo_full), 32'd0);
    chk("mid_rst_state",    32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_overflow", 32'(overflow),  32'd0);
    tick();
    resetn  = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    chk("mid_no_frame", 32'(idle_ok), 32'd1);

    // Mapping ends: '0' and 'F' back to back
    write_one(4'h0);
    write_one(4'hF);
    check_frame(8'h30, 0, 1'b0, "z0");
    gap("z0");
    check_frame(8'h46, 0, 1'b1, "zF");
    chk("end_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
